// File: rtl/l1_l2_pkg.sv
// Shared types and helpers for the L1-to-L2 request arbiter.
package l1_l2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RELEASE
    } arb_state_t;

    localparam int DEF_TAG_W   = 21;
    localparam int DEF_INDEX_W = 5;
    localparam int DEF_LINE_W  = 512;
    localparam int DEF_CNT_W   = 16;

    // Low bit of requester r's field inside a packed per-requester bus.
    function automatic int slice_lo(input int r, input int w);
        return r * w;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first active requester at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] active,
    input  logic [PTR_W-1:0]   rr_ptr,
    output logic [NUM_REQ-1:0] pick,
    output logic [PTR_W-1:0]   pick_idx,
    output logic               valid
);

    int unsigned idx;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        valid    = 1'b0;
        idx      = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr) + k) % NUM_REQ;
            if (!valid && active[idx]) begin
                pick[idx] = 1'b1;
                pick_idx  = PTR_W'(idx);
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Round-robin arbiter multiplexing NUM_REQ L1 requesters onto the single L2
// request port; the granted request is latched and held until L2 answers.
module l1_l2_arbiter
    import l1_l2_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int TAG_W   = DEF_TAG_W,
    parameter int INDEX_W = DEF_INDEX_W,
    parameter int LINE_W  = DEF_LINE_W,
    parameter int CNT_W   = DEF_CNT_W
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic [NUM_REQ-1:0]           req_read_i,
    input  logic [NUM_REQ-1:0]           req_write_i,
    input  logic [NUM_REQ*TAG_W-1:0]     req_tag_i,
    input  logic [NUM_REQ*INDEX_W-1:0]   req_index_i,
    input  logic [NUM_REQ*TAG_W-1:0]     req_wtag_i,
    input  logic [NUM_REQ*INDEX_W-1:0]   req_windex_i,
    input  logic [NUM_REQ*LINE_W-1:0]    req_wdata_i,
    output logic [NUM_REQ-1:0]           ready_o,
    output logic                         read_L1_L2,
    output logic                         write_L1_L2,
    output logic [TAG_W-1:0]             tag_L1_L2,
    output logic [INDEX_W-1:0]           index_L1_L2,
    output logic [TAG_W-1:0]             write_tag_L1_L2,
    output logic [INDEX_W-1:0]           write_index_L1_L2,
    output logic [LINE_W-1:0]            write_data_L1_L2,
    input  logic                         ready_L2_L1,
    output logic [NUM_REQ-1:0]           grant_o,
    output logic [CNT_W-1:0]             txn_cnt_o
);

    localparam int PTR_W = $clog2(NUM_REQ);

    arb_state_t           state;
    logic [PTR_W-1:0]     rr_ptr;
    logic [PTR_W-1:0]     grant_idx;
    logic [NUM_REQ-1:0]   active;
    logic [NUM_REQ-1:0]   pick;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_valid;

    assign active = req_read_i | req_write_i;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_rr_pick (
        .active   (active),
        .rr_ptr   (rr_ptr),
        .pick     (pick),
        .pick_idx (pick_idx),
        .valid    (pick_valid)
    );

    // Completion is only forwarded to the owner, and only while it owns L2.
    assign ready_o = (state == BUSY && ready_L2_L1) ? grant_o : '0;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state             <= IDLE;
            rr_ptr            <= '0;
            grant_idx         <= '0;
            grant_o           <= '0;
            read_L1_L2        <= 1'b0;
            write_L1_L2       <= 1'b0;
            tag_L1_L2         <= '0;
            index_L1_L2       <= '0;
            write_tag_L1_L2   <= '0;
            write_index_L1_L2 <= '0;
            write_data_L1_L2  <= '0;
            txn_cnt_o         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        read_L1_L2        <= req_read_i[pick_idx];
                        write_L1_L2       <= req_write_i[pick_idx];
                        tag_L1_L2         <= req_tag_i[slice_lo(int'(pick_idx), TAG_W) +: TAG_W];
                        index_L1_L2       <= req_index_i[slice_lo(int'(pick_idx), INDEX_W) +: INDEX_W];
                        write_tag_L1_L2   <= req_wtag_i[slice_lo(int'(pick_idx), TAG_W) +: TAG_W];
                        write_index_L1_L2 <= req_windex_i[slice_lo(int'(pick_idx), INDEX_W) +: INDEX_W];
                        write_data_L1_L2  <= req_wdata_i[slice_lo(int'(pick_idx), LINE_W) +: LINE_W];
                        grant_o           <= pick;
                        grant_idx         <= pick_idx;
                        state             <= BUSY;
                    end
                end
                BUSY: begin
                    if (ready_L2_L1) begin
                        read_L1_L2  <= 1'b0;
                        write_L1_L2 <= 1'b0;
                        grant_o     <= '0;
                        rr_ptr      <= (grant_idx == PTR_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                        txn_cnt_o   <= txn_cnt_o + 1'b1;
                        state       <= RELEASE;
                    end
                end
                // Dead cycle so the served L1 can drop its request first.
                RELEASE: state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule
